// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline-register bundle. It carries the ID-stage instruction fields, the hazard and forwarding
// controls, the WB write port, and the registered EX-side fields together with the forwarded operands.
interface id_ex_pipe_reg_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
);
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [4:0]         id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]    id_rs1_data, id_rs2_data, id_imm;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump;
  logic [2:0]         id_mem_size;
  logic [1:0]         id_wb_sel;
  logic               id_ex_stall, id_ex_flush, ex_redirect;
  logic [1:0]         forward_a, forward_b;
  logic [XLEN-1:0]    ex_mem_fwd_data;
  logic [4:0]         wb_rd;
  logic               wb_we;
  logic [XLEN-1:0]    wb_data;

  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [4:0]         ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]    ex_imm;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump;
  logic [2:0]         ex_mem_size;
  logic [1:0]         ex_wb_sel;
  logic [XLEN-1:0]    ex_op_a, ex_rs2_fwd, ex_op_b;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_alu_op,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_mem_size,
           id_wb_sel, id_ex_stall, id_ex_flush, ex_redirect, forward_a, forward_b,
           ex_mem_fwd_data, wb_rd, wb_we, wb_data,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_op, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_mem_size, ex_wb_sel,
           ex_op_a, ex_rs2_fwd, ex_op_b
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_alu_op,
           id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch, id_jump, id_mem_size,
           id_wb_sel, id_ex_stall, id_ex_flush, ex_redirect, forward_a, forward_b,
           ex_mem_fwd_data, wb_rd, wb_we, wb_data,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_op, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_mem_size, ex_wb_sel,
           ex_op_a, ex_rs2_fwd, ex_op_b
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble/stall control, WB write-through into held operands, and EX forwarding.
// When ID_EX_PERF_CNT_EN is defined, the perf_bubble_cnt and perf_stall_cnt counters are added.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  id_ex_pipe_reg_if.slave ex_if
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         mem_size;
    logic               reg_write;
    logic [1:0]         wb_sel;
    logic               branch;
    logic               jump;
  } ex_fields_t;

  ex_fields_t ex_q, ex_d;
  logic       kill, hold, wb_live;

  assign kill    = ex_if.ex_redirect | ex_if.id_ex_flush;
  assign hold    = ~kill & ex_if.id_ex_stall;
  assign wb_live = ex_if.wb_we & (ex_if.wb_rd != 5'd0);

  always_comb begin
    ex_d = ex_q;
    if (kill) begin
      ex_d = '0;
    end else if (hold) begin
      // Operands held across a stall would go stale if WB retires their producer meanwhile.
      if (wb_live && ex_if.wb_rd == ex_q.rs1) ex_d.rs1_data = ex_if.wb_data;
      if (wb_live && ex_if.wb_rd == ex_q.rs2) ex_d.rs2_data = ex_if.wb_data;
    end else if (!ex_if.id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = ex_if.id_pc;
      ex_d.rs1       = ex_if.id_rs1;
      ex_d.rs2       = ex_if.id_rs2;
      ex_d.rd        = ex_if.id_rd;
      ex_d.rs1_data  = (wb_live && ex_if.wb_rd == ex_if.id_rs1) ? ex_if.wb_data : ex_if.id_rs1_data;
      ex_d.rs2_data  = (wb_live && ex_if.wb_rd == ex_if.id_rs2) ? ex_if.wb_data : ex_if.id_rs2_data;
      ex_d.imm       = ex_if.id_imm;
      ex_d.alu_op    = ex_if.id_alu_op;
      ex_d.alu_src   = ex_if.id_alu_src;
      ex_d.mem_read  = ex_if.id_mem_read;
      ex_d.mem_write = ex_if.id_mem_write;
      ex_d.mem_size  = ex_if.id_mem_size;
      ex_d.reg_write = ex_if.id_reg_write;
      ex_d.wb_sel    = ex_if.id_wb_sel;
      ex_d.branch    = ex_if.id_branch;
      ex_d.jump      = ex_if.id_jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      idx,
                                              input logic [1:0]      sel,
                                              input logic [XLEN-1:0] held,
                                              input logic [XLEN-1:0] exmem,
                                              input logic [XLEN-1:0] wb);
    if (idx == 5'd0) return '0;
    case (sel)
      2'b10:   return exmem;
      2'b01:   return wb;
      default: return held;
    endcase
  endfunction

  assign ex_if.ex_op_a    = fwd_sel(ex_q.rs1, ex_if.forward_a, ex_q.rs1_data,
                                    ex_if.ex_mem_fwd_data, ex_if.wb_data);
  assign ex_if.ex_rs2_fwd = fwd_sel(ex_q.rs2, ex_if.forward_b, ex_q.rs2_data,
                                    ex_if.ex_mem_fwd_data, ex_if.wb_data);
  assign ex_if.ex_op_b    = ex_q.alu_src ? ex_q.imm : ex_if.ex_rs2_fwd;

  assign ex_if.ex_valid     = ex_q.valid;
  assign ex_if.ex_pc        = ex_q.pc;
  assign ex_if.ex_rs1       = ex_q.rs1;
  assign ex_if.ex_rs2       = ex_q.rs2;
  assign ex_if.ex_rd        = ex_q.rd;
  assign ex_if.ex_imm       = ex_q.imm;
  assign ex_if.ex_alu_op    = ex_q.alu_op;
  assign ex_if.ex_alu_src   = ex_q.alu_src;
  assign ex_if.ex_mem_read  = ex_q.mem_read;
  assign ex_if.ex_mem_write = ex_q.mem_write;
  assign ex_if.ex_mem_size  = ex_q.mem_size;
  assign ex_if.ex_reg_write = ex_q.reg_write;
  assign ex_if.ex_wb_sel    = ex_q.wb_sel;
  assign ex_if.ex_branch    = ex_q.branch;
  assign ex_if.ex_jump      = ex_q.jump;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d, stall_cnt_q, stall_cnt_d;

  // Only redirect/flush commands count as bubbles; an idle ID slot does not.
  assign bubble_cnt_d = bubble_cnt_q + {31'd0, kill};
  assign stall_cnt_d  = stall_cnt_q + {31'd0, hold};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_stall_cnt  = stall_cnt_q;
`endif

endmodule
